// File: rtl/sha3_pkg.sv
// Shared SHA-3 definitions: lane-array type, sponge rates, pad bytes, loader states.
package sha3_pkg;

    typedef logic [0:4][0:4][63:0] keccak_state_t;

    localparam int RATE_SHA3_224 = 1152;
    localparam int RATE_SHA3_256 = 1088;
    localparam int RATE_SHA3_384 = 832;
    localparam int RATE_SHA3_512 = 576;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    localparam logic [7:0] PAD_SHA3  = 8'h06;
    localparam logic [7:0] PAD_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_FINAL = 8'h80;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_PAD  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/keccak_flat2lanes.sv
// Combinational map of a flat 1600-bit state onto the 5x5 lane array.
module keccak_flat2lanes
    import sha3_pkg::*;
(
    input  logic [1599:0]  flat,
    output keccak_state_t  lanes
);

    for (genvar y = 0; y < 5; y++) begin : g_row
        for (genvar x = 0; x < 5; x++) begin : g_col
            assign lanes[x][y] = flat[64*(5*y+x) +: 64];
        end
    end

endmodule

// File: rtl/keccak_axis_absorb_loader.sv
// AXI4-Stream message ingest: packs beats into rate blocks, applies multi-rate
// padding on TLAST and hands blocks to the permutation core.
module keccak_axis_absorb_loader
    import sha3_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         RATE_BITS  = RATE_SHA3_256,
    parameter logic [7:0] DOMAIN_PAD = PAD_SHA3
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  S_TVALID,
    output logic                  S_TREADY,
    input  logic [DATA_WIDTH-1:0] S_TDATA,
    input  logic                  S_TLAST,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic                  blk_last,
    output keccak_state_t         blk_state
);

    localparam int WORDS = RATE_BITS / DATA_WIDTH;
    localparam int CW    = $clog2(WORDS);
    localparam int IW    = $clog2(RATE_BITS);

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic                 pend_pad;
    logic                 last;
    logic [RATE_BITS-1:0] blk_buf;
    logic [RATE_BITS-1:0] pad_vec;
    logic [IW-1:0]        word_bit;
    logic                 last_word;

    assign word_bit  = IW'(cnt) * IW'(DATA_WIDTH);
    assign last_word = (cnt == CW'(WORDS - 1));

    // Domain byte lands right after the data; when that is the final rate byte
    // the two pad bytes merge into one.
    always_comb begin
        pad_vec = '0;
        pad_vec[word_bit +: 8] = DOMAIN_PAD;
        pad_vec[RATE_BITS-8 +: 8] = pad_vec[RATE_BITS-8 +: 8] | PAD_FINAL;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pend_pad <= 1'b0;
            last     <= 1'b0;
            blk_buf  <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FILL;
                ST_FILL: begin
                    if (S_TVALID) begin
                        blk_buf[word_bit +: DATA_WIDTH] <= S_TDATA;
                        if (last_word) begin
                            // A TLAST here still needs a separate pad-only block.
                            state    <= ST_HOLD;
                            last     <= 1'b0;
                            pend_pad <= S_TLAST;
                        end else begin
                            cnt   <= cnt + CW'(1);
                            state <= S_TLAST ? ST_PAD : ST_FILL;
                        end
                    end
                end
                ST_PAD: begin
                    blk_buf <= blk_buf | pad_vec;
                    last    <= 1'b1;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (blk_ready) begin
                        blk_buf <= '0;
                        cnt     <= '0;
                        last    <= 1'b0;
                        if (pend_pad) begin
                            pend_pad <= 1'b0;
                            state    <= ST_PAD;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign S_TREADY  = (state == ST_FILL);
    assign blk_valid = (state == ST_HOLD);
    assign blk_last  = blk_valid & last;

    keccak_flat2lanes u_unpack (
        .flat  ({{(1600-RATE_BITS){1'b0}}, blk_buf}),
        .lanes (blk_state)
    );

endmodule

// File: doc/keccak_axis_absorb_loader.md
# keccak_axis_absorb_loader

Parametrised AXI4-Stream ingest stage for the SHA-3 datapath. It accepts message beats of configurable width and packs them into rate-sized Keccak input blocks. It applies SHA-3/SHAKE multi-rate padding on TLAST and hands each block to the permutation core over a valid/ready handshake, as a 5x5x64 lane array. All logic runs on the rising edge. Message addressing comes from an internal beat counter; no TDEST is used.

## Interface
- DATA_WIDTH, 64: beat width in bits; one of 8, 16, 32, 64; must divide RATE_BITS.
- RATE_BITS, 1088: sponge rate (1152/1088/832/576 for SHA3-224/256/384/512; 1344/1088 for SHAKE128/256); multiple of 64.
- DOMAIN_PAD, 8'h06: domain-separation byte (8'h1F for SHAKE).
- ACLK  in  1  clock.
- ARESETn  in  1  reset. One clock; reset is asynchronous and active-low.
- S_TVALID  in  1  input beat valid.
- S_TREADY  out  1  input beat accepted when high with S_TVALID.
- S_TDATA  in  DATA_WIDTH  message data; little-endian byte order.
- S_TLAST  in  1  last beat of message.
- blk_valid  out  1  block available.
- blk_ready  in  1  core consumes block.
- blk_last  out  1  block is the final (padded) block of the message.
- blk_state  out  [0:4][0:4][63:0]  block. Lane [x][y] = flat bits [64*(5y+x)+63 : 64*(5y+x)]. Capacity lanes (flat bit ≥ RATE_BITS) are always 0.

## Operation
- Internal storage: flat RATE_BITS buffer, word counter cnt (0..RATE_BITS/DATA_WIDTH-1), pend_pad flag, last flag.
- States:
  - IDLE: after reset; moves to FILL unconditionally on the next edge.
  - FILL: S_TREADY=1. An accepted beat is written to buf[DATA_WIDTH*cnt +: DATA_WIDTH].
    - Beat fills the final word: go to HOLD; last=0; pend_pad=S_TLAST.
    - Otherwise, S_TLAST=1: cnt++; go to PAD.
    - Otherwise, S_TLAST=0: cnt++; stay in FILL.
  - PAD: one cycle. buf byte (cnt*DATA_WIDTH/8) |= DOMAIN_PAD; buf byte (RATE_BITS/8-1) |= 8'h80. When these are the same byte the result is DOMAIN_PAD|8'h80 (8'h86 by default). Then last=1; go to HOLD.
  - HOLD: blk_valid=1, S_TREADY=0, blk_last=last. On blk_ready: buf cleared to 0, cnt=0, last=0.
    - pend_pad=1: clear pend_pad; go to PAD, which produces a pad-only block: byte 0 = DOMAIN_PAD, byte RATE/8-1 = 8'h80.
    - pend_pad=0: go to FILL.
- Bytes after the last data byte are zero because the buffer is cleared on every handoff.
- A message is at least one beat. Messages are beat-granular; no TKEEP.
- blk_state is stable whenever blk_valid=1 and until it is consumed.
- Reset at any time returns to IDLE and clears buffer, cnt, pend_pad and last. Any block in flight is discarded.

## Timing
- Reset values: S_TREADY=0, blk_valid=0, blk_last=0, blk_state=0.
- S_TREADY rises on the first edge after ARESETn deasserts.
- Full block without TLAST: blk_valid on the cycle after the final beat is accepted (latency 1).
- TLAST on a partial block: one PAD cycle, then blk_valid (latency 2).
- TLAST on the final word: data block after 1 cycle. After its handoff, PAD then the pad block, 2 cycles after blk_ready.
- Handoff: S_TREADY returns high on the cycle after blk_valid&&blk_ready. Sustained throughput is RATE_BITS/DATA_WIDTH beats per RATE_BITS/DATA_WIDTH+1 cycles.
- blk_valid never drops without blk_ready. S_TVALID held during HOLD is not consumed.

## Structure
- Shared package sha3_pkg: lane-array typedef keccak_state_t ([0:4][0:4][63:0]), rate constants per variant, pad constants (8'h06, 8'h1F, 8'h80), state enum.
- Sub-module keccak_flat2lanes: combinational flat[1599:0] to lane-array mapping. Reused by the output unpacker.

## Test plan
- Reset: hold ARESETn low with S_TVALID=1 -> all outputs 0; S_TREADY=1 one edge after release; no beat captured during reset.
- Default params, single beat 64'h0000000000636261 ("abc"), TLAST -> blk_valid 2 cycles later with:
  - lane[0][0]=64'h636261;
  - lane[1][0]=64'h06;
  - lane[1][3]=64'h8000000000000000;
  - all other lanes 0; blk_last=1.
- 17 beats, TLAST on 17th -> block 1 holds the data, blk_last=0. After blk_ready, pad block: lane[0][0]=64'h06, lane[1][3]=64'h8000000000000000, blk_last=1.
- Backpressure: blk_ready=0 for 10 cycles with S_TVALID=1 -> S_TREADY=0 and blk_state constant throughout; the pending beat is accepted the cycle after handoff, into word 0.
- Reset mid-fill after 5 beats -> next 1-beat TLAST message produces word0=data, word1 byte0=06, as in the single-beat case.
- DATA_WIDTH=8: 135 bytes of 8'hAA, TLAST -> byte 135 = 8'h86, bytes 0..134 = 8'hAA, blk_last=1; SHAKE variant (DOMAIN_PAD=8'h1F) -> byte 135 = 8'h9F.
